// File: rtl/writeback_regfile_if.sv
// rtl/writeback_regfile_if.sv - writeback bus and decode read-port bundle for writeback_regfile
//
// Purpose: groups the retiring-instruction writeback signals and the two
// decode read ports of the register file.
// Signals:
//   wb_valid      one instruction retires this cycle
//   icode, cnd    instruction code and execute condition (cmovXX qualifier)
//   dstE, dstM    destination IDs for valE / valM (0xF = none)
//   valE, valM    ALU result and memory read data
//   stat_in       instruction status (1=AOK 2=HLT 3=ADR 4=INS)
//   srcA, srcB    read-port IDs; valA, valB read-port data
// master: pipeline side (drives writeback and read IDs)
// slave:  register file side (returns read data)
interface writeback_regfile_if;
    logic        wb_valid;
    logic [3:0]  icode;
    logic        cnd;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [2:0]  stat_in;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [63:0] valA;
    logic [63:0] valB;

    modport master (
        output wb_valid, icode, cnd, dstE, dstM, valE, valM, stat_in, srcA, srcB,
        input  valA, valB
    );

    modport slave (
        input  wb_valid, icode, cnd, dstE, dstM, valE, valM, stat_in, srcA, srcB,
        output valA, valB
    );
endinterface

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - Y86-64 style writeback stage with 15-entry register file
//
// Purpose: commits retiring instructions into R[0..14], tracks processor
// status and a retired-instruction counter, and stops on the first
// non-AOK status until reset.
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   wb        writeback_regfile_if.slave (writeback bus + read ports)
//   stat      latched processor status
//   halted    high once the processor has stopped
//   retired   count of committed instructions (wraps at 2^64)
module writeback_regfile (
    input  logic                clk,
    input  logic                rst_n,
    writeback_regfile_if.slave  wb,
    output logic [2:0]          stat,
    output logic                halted,
    output logic [63:0]         retired
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] ICMOV = 4'h2;
    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_INS = 3'd4;

    typedef enum logic {
        RUN  = 1'b0,
        STOP = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  stat_eff;
    logic        commit;
    logic        stop_now;
    logic        we_e;
    logic        we_m;
    logic [63:0] regs [0:14];

    always_comb begin
        state_d  = state_q;
        stat_eff = wb.stat_in;
        commit   = 1'b0;
        stop_now = 1'b0;
        // Unknown status codes are treated as an invalid instruction.
        if (wb.stat_in == 3'd0 || wb.stat_in > S_INS) begin
            stat_eff = S_INS;
        end
        if (state_q == RUN && wb.wb_valid) begin
            if (stat_eff == S_AOK) begin
                commit = 1'b1;
            end else begin
                stop_now = 1'b1;
                state_d  = STOP;
            end
        end
    end

    // A cmovXX whose condition failed retires but does not write its E result.
    assign we_e = commit && (wb.dstE != RNONE) && !(wb.icode == ICMOV && !wb.cnd);
    assign we_m = commit && (wb.dstM != RNONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            stat    <= S_AOK;
            retired <= '0;
        end else begin
            state_q <= state_d;
            if (stop_now) begin
                stat <= stat_eff;
            end
            // HLT itself counts as retired; ADR/INS faults do not.
            if (commit || (stop_now && stat_eff == S_HLT)) begin
                retired <= retired + 64'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (we_e) begin
                regs[wb.dstE] <= wb.valE;
            end
            // Issued after the E write so the M value wins when dstE == dstM.
            if (we_m) begin
                regs[wb.dstM] <= wb.valM;
            end
        end
    end

    // Reads see the pre-edge array contents; no write bypass.
    assign wb.valA = (wb.srcA == RNONE) ? 64'd0 : regs[wb.srcA];
    assign wb.valB = (wb.srcB == RNONE) ? 64'd0 : regs[wb.srcB];

    assign halted = (state_q == STOP);

endmodule

// File: tb/tb_writeback_regfile.sv
// tb/tb_writeback_regfile.sv - directed self-checking bench for writeback_regfile
module tb_writeback_regfile;

    logic        clk;
    logic        rst_n;
    logic [2:0]  stat;
    logic        halted;
    logic [63:0] retired;

    int n_checks;
    int n_pass;

    writeback_regfile_if wb();

    writeback_regfile dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wb      (wb.slave),
        .stat    (stat),
        .halted  (halted),
        .retired (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic read_a(input string tag, input logic [3:0] id, input logic [63:0] exp);
        wb.srcA = id;
        #1;
        check(tag, wb.valA, exp);
    endtask

    task automatic read_b(input string tag, input logic [3:0] id, input logic [63:0] exp);
        wb.srcB = id;
        #1;
        check(tag, wb.valB, exp);
    endtask

    // Presents one retiring instruction for exactly one rising edge.
    task automatic retire(input logic [3:0] ic, input logic c, input logic [3:0] de,
                          input logic [3:0] dm, input logic [63:0] ve, input logic [63:0] vm,
                          input logic [2:0] st);
        @(negedge clk);
        wb.wb_valid = 1'b1;
        wb.icode    = ic;
        wb.cnd      = c;
        wb.dstE     = de;
        wb.dstM     = dm;
        wb.valE     = ve;
        wb.valM     = vm;
        wb.stat_in  = st;
        @(posedge clk);
        #1;
        wb.wb_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        wb.wb_valid = 1'b0;
        wb.icode    = 4'h3;
        wb.dstE     = 4'h1;
        wb.dstM     = 4'h2;
        wb.valE     = 64'hFFFF;
        wb.valM     = 64'hEEEE;
        wb.stat_in  = 3'd1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        rst_n       = 1'b0;
        wb.wb_valid = 1'b0;
        wb.icode    = 4'h0;
        wb.cnd      = 1'b0;
        wb.dstE     = 4'hF;
        wb.dstM     = 4'hF;
        wb.valE     = '0;
        wb.valM     = '0;
        wb.stat_in  = 3'd1;
        wb.srcA     = 4'h0;
        wb.srcB     = 4'hE;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valA", wb.valA, 64'd0);
        check("rst_valB", wb.valB, 64'd0);
        check("rst_stat", {61'd0, stat}, 64'd1);
        check("rst_halted", {63'd0, halted}, 64'd0);
        check("rst_retired", retired, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // irmovq into R3; pre-edge read must still show the old value
        @(negedge clk);
        wb.srcA     = 4'h3;
        wb.wb_valid = 1'b1;
        wb.icode    = 4'h3;
        wb.cnd      = 1'b1;
        wb.dstE     = 4'h3;
        wb.dstM     = 4'hF;
        wb.valE     = 64'h1234;
        wb.stat_in  = 3'd1;
        #1;
        check("irmov_prewrite", wb.valA, 64'd0);
        @(posedge clk);
        #1;
        wb.wb_valid = 1'b0;
        check("irmov_r3", wb.valA, 64'h1234);
        check("irmov_retired", retired, 64'd1);
        read_a("rnone_read", 4'hF, 64'd0);

        // cmovXX with cnd=0 suppresses E write but still retires
        retire(4'h2, 1'b0, 4'h5, 4'hF, 64'hAA, 64'h0, 3'd1);
        read_a("cmov_nc_r5", 4'h5, 64'd0);
        check("cmov_nc_retired", retired, 64'd2);
        retire(4'h2, 1'b1, 4'h5, 4'hF, 64'hAA, 64'h0, 3'd1);
        read_a("cmov_c_r5", 4'h5, 64'hAA);
        check("cmov_c_retired", retired, 64'd3);

        // popq: M write wins over E on the same register
        retire(4'hB, 1'b1, 4'h4, 4'h4, 64'h108, 64'hDEAD, 3'd1);
        read_a("popq_r4", 4'h4, 64'hDEAD);

        // distinct E and M destinations both written
        retire(4'h5, 1'b1, 4'h6, 4'h7, 64'h1, 64'h2, 3'd1);
        read_a("dual_r6", 4'h6, 64'h1);
        read_b("dual_r7", 4'h7, 64'h2);
        read_b("r14_untouched", 4'hE, 64'd0);
        check("dual_retired", retired, 64'd5);

        // wb_valid low holds everything
        idle_cycle();
        read_a("idle_r1", 4'h1, 64'd0);
        read_b("idle_r2", 4'h2, 64'd0);
        check("idle_retired", retired, 64'd5);

        // ADR fault: no write, no retire, processor stops
        retire(4'h5, 1'b1, 4'h1, 4'hF, 64'h7, 64'h0, 3'd3);
        read_a("adr_r1", 4'h1, 64'd0);
        check("adr_stat", {61'd0, stat}, 64'd3);
        check("adr_halted", {63'd0, halted}, 64'd1);
        check("adr_retired", retired, 64'd5);
        retire(4'h3, 1'b1, 4'h1, 4'hF, 64'h9, 64'h0, 3'd1);
        read_a("stop_r1", 4'h1, 64'd0);
        check("stop_retired", retired, 64'd5);
        check("stop_stat", {61'd0, stat}, 64'd3);
        read_a("stop_read_live", 4'h4, 64'hDEAD);

        // reset held across an edge with a valid commit presented
        @(negedge clk);
        rst_n       = 1'b0;
        wb.wb_valid = 1'b1;
        wb.icode    = 4'h3;
        wb.dstE     = 4'h8;
        wb.dstM     = 4'hF;
        wb.valE     = 64'h55;
        wb.stat_in  = 3'd1;
        @(posedge clk);
        #1;
        read_a("rst_override_r8", 4'h8, 64'd0);
        check("rst_override_retired", retired, 64'd0);
        @(negedge clk);
        rst_n       = 1'b1;
        wb.wb_valid = 1'b0;

        // write R3, then HLT: HLT retires and stops
        retire(4'h3, 1'b1, 4'h3, 4'hF, 64'h77, 64'h0, 3'd1);
        retire(4'h0, 1'b1, 4'hF, 4'hF, 64'h0, 64'h0, 3'd2);
        check("hlt_stat", {61'd0, stat}, 64'd2);
        check("hlt_halted", {63'd0, halted}, 64'd1);
        check("hlt_retired", retired, 64'd2);
        read_a("hlt_r3", 4'h3, 64'h77);

        // asynchronous reset between edges takes effect immediately
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_stat", {61'd0, stat}, 64'd1);
        check("async_halted", {63'd0, halted}, 64'd0);
        check("async_retired", retired, 64'd0);
        read_a("async_r3", 4'h3, 64'd0);
        read_b("async_r4", 4'h4, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // out-of-range status is treated as INS
        retire(4'h3, 1'b1, 4'h2, 4'hF, 64'h3, 64'h0, 3'd6);
        check("bad_stat", {61'd0, stat}, 64'd4);
        check("bad_halted", {63'd0, halted}, 64'd1);
        check("bad_retired", retired, 64'd0);
        read_a("bad_r2", 4'h2, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 Parameters: none; register count fixed at 15 (IDs 0x0-0xE), ID 0xF = RNONE.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset; one clock domain only.
REQ-004 wb_valid  input  1  one instruction is retiring this cycle.
REQ-005 icode  input  4  retiring instruction code.
REQ-006 cnd  input  1  condition result from execute; qualifies cmovXX writes.
REQ-007 dstE  input  4  destination ID for valE; 0xF = no write.
REQ-008 dstM  input  4  destination ID for valM; 0xF = no write.
REQ-009 valE  input  64  ALU result to write back.
REQ-010 valM  input  64  memory-stage read data to write back.
REQ-011 stat_in  input  3  instruction status: 1=AOK, 2=HLT, 3=ADR, 4=INS.
REQ-012 srcA, srcB  input  4 each  decode read-port IDs.
REQ-013 valA, valB  output  64 each  read-port data.
REQ-014 stat  output  3  latched processor status.
REQ-015 halted  output  1  high once the processor has stopped.
REQ-016 retired  output  64  count of committed instructions.

Function
REQ-017 Read ports are combinational from the array; srcX = 0xF gives 0; no same-cycle write bypass (SEQ semantics: reads return pre-edge value).
REQ-018 Commit occurs on the rising edge when wb_valid=1, halted=0 and stat_in=AOK.
REQ-019 On commit, dstE != 0xF writes valE to R[dstE], except icode=0x2 (cmovXX) with cnd=0, which suppresses the E write.
REQ-020 On commit, dstM != 0xF writes valM to R[dstM].
REQ-021 If dstE == dstM != 0xF in one commit, the M write wins (popq %rsp result = popped value).
REQ-022 On commit, retired increments by 1, wrapping modulo 2^64.
REQ-023 FSM states RUN and STOP; reset -> RUN; output halted = (state == STOP).
REQ-024 RUN -> STOP on the edge where wb_valid=1 and stat_in != AOK; stat latches stat_in; no register write; retired increments only for stat_in=HLT.
REQ-025 STOP is terminal until reset: all writes, stat updates and retired increments are ignored; read ports stay live.
REQ-026 wb_valid=0 holds all state; inputs are don't-care.
REQ-027 stat_in values outside 1-4 while wb_valid=1 are treated as INS (stat=4, STOP).

Reset
REQ-028 rst_n low asynchronously forces R[0..14]=0, stat=1 (AOK), state RUN (halted=0), retired=0.
REQ-029 Reset asserted mid-operation overrides any same-edge commit; first commit is on the first rising edge with rst_n high.

Verification
REQ-030 Reset, then srcA=0x0, srcB=0xE -> valA=0, valB=0, stat=1, halted=0, retired=0.
REQ-031 Commit irmovq (icode=3, dstE=0x3, valE=0x1234, dstM=0xF) -> next cycle srcA=3 gives 0x1234, retired=1; same-cycle read before edge gives 0.
REQ-032 cmovXX icode=2, dstE=0x5, valE=0xAA, cnd=0 -> R5 unchanged (0), retired increments; repeat with cnd=1 -> R5=0xAA.
REQ-033 popq: dstE=dstM=0x4, valE=0x108, valM=0xDEAD -> R4=0xDEAD.
REQ-034 stat_in=3 (ADR) with dstE=0x1, valE=7 -> R1 unchanged, stat=3, halted=1, retired unchanged; later AOK commit to R1 -> ignored.
REQ-035 Halted at stat=2, pulse rst_n low between edges -> immediately stat=1, halted=0, retired=0, all registers 0.
